tstate_sequencer: RTL

//  Owns the CPU's instruction timing. Holds the registered T-state and instruction register (IR).

---
 rtl/tstate_sequencer_pkg.sv | 26 ++
 rtl/tstate_sequencer_int_arbiter.sv | 54 +++++
 rtl/tstate_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tstate_sequencer_pkg.sv
// Shared timing, execution-type and interrupt-source encodings for the T-state sequencer.
package tstate_sequencer_pkg;

  localparam logic [6:0] T0 = 7'b0000001;
  localparam logic [6:0] T1 = 7'b0000010;
  localparam logic [6:0] T2 = 7'b0000100;
  localparam logic [6:0] T3 = 7'b0001000;
  localparam logic [6:0] T4 = 7'b0010000;
  localparam logic [6:0] T5 = 7'b0100000;
  localparam logic [6:0] T6 = 7'b1000000;

  localparam logic [2:0] ExecNorm   = 3'd0;
  localparam logic [2:0] ExecRmw    = 3'd1;
  localparam logic [2:0] ExecBranch = 3'd2;

  localparam logic [1:0] IntNone  = 2'b00;
  localparam logic [1:0] IntIrq   = 2'b01;
  localparam logic [1:0] IntNmi   = 2'b10;
  localparam logic [1:0] IntReset = 2'b11;

  localparam logic [7:0] OpBrk = 8'h00;

  localparam logic [0:0] StRun = 1'b0;
  localparam logic [0:0] StJam = 1'b1;

endpackage

// File: rtl/tstate_sequencer_int_arbiter.sv
// NMI edge detection and pending latch, IRQ masking, and RESET>NMI>IRQ priority encode.
module tstate_sequencer_int_arbiter
  import tstate_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hold_i,
  input  logic       fetch_i,
  input  logic       nmi_ni,
  input  logic       irq_ni,
  input  logic       irq_mask_i,
  output logic       take_o,
  output logic [1:0] src_o
);

  logic nmi_q, nmi_d;
  logic nmi_pend_q, nmi_pend_d;
  logic nmi_edge;

  assign nmi_edge = nmi_q & ~nmi_ni;
  assign nmi_d    = nmi_ni;

  always_comb begin
    take_o = 1'b0;
    src_o  = IntNone;
    if (nmi_pend_q) begin
      take_o = 1'b1;
      src_o  = IntNmi;
    end else if (!irq_ni && !irq_mask_i) begin
      take_o = 1'b1;
      src_o  = IntIrq;
    end
  end

  // Set is applied after clear so a fresh edge on the fetch edge is never lost.
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if (!hold_i) begin
      if (fetch_i && nmi_pend_q) nmi_pend_d = 1'b0;
      if (nmi_edge)              nmi_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nmi_q      <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_q      <= nmi_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

endmodule

// File: rtl/tstate_sequencer.sv
// CPU instruction timing: registered T-state and IR, 3:1 control-generator mux,
// BRK injection at the T1 fetch edge and halt on undecodable selections.
module tstate_sequencer
  import tstate_sequencer_pkg::*;
#(
  parameter int unsigned T_W    = 7,
  parameter int unsigned CTRL_W = 62,
  parameter int unsigned OP_W   = 8
) (
  input  logic              phi2,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [OP_W-1:0]   dataIn,
  input  logic [7:0]        statusReg,
  input  logic              nmi_n,
  input  logic              irq_n,
  input  logic [2:0]        execType,
  input  logic [T_W-1:0]    nextT_norm,
  input  logic [T_W-1:0]    nextT_rmw,
  input  logic [T_W-1:0]    nextT_br,
  input  logic [CTRL_W-1:0] ctrl_norm,
  input  logic [CTRL_W-1:0] ctrl_rmw,
  input  logic [CTRL_W-1:0] ctrl_br,
  output logic [T_W-1:0]    currT,
  output logic [OP_W-1:0]   opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic [1:0]        intSrc,
  output logic              sync,
  output logic              jam
);

  logic [T_W-1:0]    t_q, t_d;
  logic [OP_W-1:0]   ir_q, ir_d;
  logic [1:0]        int_src_q, int_src_d;
  logic [0:0]        state_q, state_d;
  logic [T_W-1:0]    next_t_sel;
  logic [CTRL_W-1:0] ctrl_sel;
  logic              type_ok, t_onehot, illegal;
  logic              running, advance, fetch;
  logic              int_take;
  logic [1:0]        int_src_sel;
  logic              unused_status;

  assign unused_status = ^{statusReg[7:3], statusReg[1:0]};

  always_comb begin
    type_ok    = 1'b1;
    next_t_sel = nextT_norm;
    ctrl_sel   = ctrl_norm;
    case (execType)
      ExecNorm: begin
        next_t_sel = nextT_norm;
        ctrl_sel   = ctrl_norm;
      end
      ExecRmw: begin
        next_t_sel = nextT_rmw;
        ctrl_sel   = ctrl_rmw;
      end
      ExecBranch: begin
        next_t_sel = nextT_br;
        ctrl_sel   = ctrl_br;
      end
      default: begin
        type_ok    = 1'b0;
        next_t_sel = '0;
        ctrl_sel   = '0;
      end
    endcase
  end

  assign t_onehot = (next_t_sel != '0) && ((next_t_sel & (next_t_sel - T_W'(1))) == '0);
  assign illegal  = !type_ok || !t_onehot;
  assign running  = (state_q == StRun);
  assign advance  = running && rdy && !illegal;
  assign fetch    = advance && (t_q == T_W'(T1));

  tstate_sequencer_int_arbiter u_int_arbiter (
    .clk_i      (phi2),
    .rst_ni     (rst_n),
    .hold_i     (!running),
    .fetch_i    (fetch),
    .nmi_ni     (nmi_n),
    .irq_ni     (irq_n),
    .irq_mask_i (statusReg[2]),
    .take_o     (int_take),
    .src_o      (int_src_sel)
  );

  // An illegal selection freezes T and IR; the only effect of that edge is entering JAM.
  always_comb begin
    t_d       = t_q;
    ir_d      = ir_q;
    int_src_d = int_src_q;
    state_d   = state_q;
    if (running && rdy) begin
      if (illegal) begin
        state_d = StJam;
      end else begin
        t_d = next_t_sel;
        if (fetch) begin
          if (int_take) begin
            ir_d      = OP_W'(OpBrk);
            int_src_d = int_src_sel;
          end else begin
            ir_d      = dataIn;
            int_src_d = IntNone;
          end
        end
      end
    end
  end

  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      t_q       <= T_W'(T2);
      ir_q      <= OP_W'(OpBrk);
      int_src_q <= IntReset;
      state_q   <= StRun;
    end else begin
      t_q       <= t_d;
      ir_q      <= ir_d;
      int_src_q <= int_src_d;
      state_q   <= state_d;
    end
  end

  assign currT  = t_q;
  assign opcode = ir_q;
  assign intSrc = int_src_q;
  assign jam    = !running;
  assign sync   = running && (t_q == T_W'(T1));
  assign ctrl   = (running && !illegal) ? ctrl_sel : '0;

endmodule
